sd_req_arbiter: RTL and testbench
=================================

Name: sd_req_arbiter

Overview:
Shares the single SD block-access port of the MiST I/O controller (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*) between two independent block-device clients, e.g. the FDC and the IDE/SD-card emulation.
- Arbitrates round-robin and latches the winner's LBA and operation.
- Drives exactly one of sd_rd/sd_wr bits at a time; client 0 maps to drive bit 0, client 1 to drive bit 1.
- Steers the sector-buffer write strobes and read-back data to/from the granted client, and times out unanswered requests.

Parameters:
TIMEOUT, 10000000, clk_sys cycles to wait in ISSUE for sd_ack rise; 0 disables timeout.

Ports:
clk_sys  in  1  system clock; every register on its rising edge
reset_n  in  1  synchronous reset, active low
c0_lba  in  32  client 0 sector LBA, sampled at grant
c0_rd  in  1  client 0 read request (level, held until c0_done)
c0_wr  in  1  client 0 write request (level, held until c0_done)
c0_busy  out  1  client 0 transaction in progress
c0_done  out  1  one-cycle completion pulse, client 0
c0_err  out  1  one-cycle timeout flag, coincident with c0_done
c0_buff_wr  out  1  gated sd_buff_wr for client 0
c0_buff_din  in  8  client 0 sector data toward SD (writes)
c1_lba, c1_rd, c1_wr, c1_busy, c1_done, c1_err, c1_buff_wr, c1_buff_din: same as client 0 for client 1
sd_lba  out  32  LBA to I/O controller
sd_rd  out  2  read request, one-hot or zero
sd_wr  out  2  write request, one-hot or zero
sd_ack  in  1  transfer acknowledge from I/O controller
sd_buff_wr  in  1  sector-buffer write strobe from I/O controller
sd_buff_din  out  8  sector data to I/O controller, muxed from granted client

Behaviour:
- Reset (reset_n=0 at edge): state=IDLE; sd_lba=0, sd_rd=0, sd_wr=0; all cN_busy/done/err=0; last_grant=1, so client 0 wins first; timeout counter=0; ack_d=0. Applies mid-transaction with no completion pulse.
- ack_d is sd_ack registered each cycle. Rise = sd_ack & ~ack_d; fall = ~sd_ack & ack_d.
- A client is requesting when cN_rd|cN_wr is high and cN_busy is low. If rd and wr are both high, the operation is a read.
- IDLE:
  - Only one client requesting: grant it.
  - Both requesting: grant the client != last_grant.
  - On grant, next edge: g=client, last_grant=client, sd_lba=cN_lba, sd_rd[g] or sd_wr[g]=1, cN_busy=1, counter=0, state=ISSUE.
  - Grant latency: request visible at edge n, outputs asserted after edge n+1.
- ISSUE:
  - Hold sd_lba and the request bit; counter increments each cycle.
  - On ack rise: clear sd_rd/sd_wr and go to XFER.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 without ack rise: clear sd_rd/sd_wr, pulse cg_done and cg_err, clear cg_busy, go to IDLE.
  - A sd_ack already high on entry is not a rise; wait for a fresh rise.
- XFER:
  - cg_buff_wr = sd_buff_wr (combinational); the other client's buff_wr = 0.
  - sd_buff_din = cg_buff_din (combinational).
  - On ack fall: go to DONE.
- DONE: one cycle; cg_done=1, cg_busy=0; next state IDLE. The same client may be re-granted on the following IDLE cycle only if the other client is not requesting.
- Outside XFER: sd_buff_din=0 and both cN_buff_wr=0. sd_ack/sd_buff_wr activity in IDLE is ignored.
- Invariants: sd_rd|sd_wr has at most one bit set; cN_busy is never high for both clients; cN_done and cN_busy are never high together.
- The counter is 32 bits and saturates. Requests dropped while busy are not queued; clients must hold them.

Test Plan:
- Single read: after reset, c0_rd=1, c0_lba=0x00001234. Expect sd_rd=2'b01 and sd_lba=0x1234 one edge later. Ack high 3 cycles later: sd_rd=0. 512 sd_buff_wr pulses give exactly 512 c0_buff_wr and 0 c1_buff_wr. Ack low: c0_done high exactly one cycle, c0_busy low with it.
- Simultaneous: c0_rd with lba 5 and c1_wr with lba 9 on the same edge after reset. c0 is served first (sd_rd=01). Then sd_wr=2'b10, sd_lba=9, and sd_buff_din equals c1_buff_din (drive 0xA5 -> 0xA5) during XFER.
- Fairness: both clients request continuously for 4 transactions. Grant order is 0,1,0,1; sd_rd/sd_wr never has two bits set.
- Timeout: TIMEOUT=100, c1_rd with sd_ack held 0. sd_rd=2'b10 for exactly 100 cycles, then 0. c1_done and c1_err pulse together; return to IDLE.
- Stale ack: sd_ack already 1 when ISSUE is entered. No transition to XFER until sd_ack goes 0 then 1.
- Reset mid-XFER, then corner case:
  - reset_n=0 for one edge during XFER: all outputs 0 next cycle, no done pulse.
  - Then c1_rd: served normally (last_grant=1 does not block a lone requester).
  - c0_rd=c0_wr=1: a read is issued (sd_rd=01, sd_wr=0).

Source files
------------

// File: rtl/sd_req_arbiter.sv
// Two-client arbiter for the MiST I/O controller SD block port: round-robin grant,
// LBA/operation latching, sector-buffer steering and ack timeout.
module sd_req_arbiter #(
   parameter int unsigned TIMEOUT = 32'd10000000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [31:0] c0_lba,
   input  logic        c0_rd,
   input  logic        c0_wr,
   output logic        c0_busy,
   output logic        c0_done,
   output logic        c0_err,
   output logic        c0_buff_wr,
   input  logic [7:0]  c0_buff_din,
   input  logic [31:0] c1_lba,
   input  logic        c1_rd,
   input  logic        c1_wr,
   output logic        c1_busy,
   output logic        c1_done,
   output logic        c1_err,
   output logic        c1_buff_wr,
   input  logic [7:0]  c1_buff_din,
   output logic [31:0] sd_lba,
   output logic [1:0]  sd_rd,
   output logic [1:0]  sd_wr,
   input  logic        sd_ack,
   input  logic        sd_buff_wr,
   output logic [7:0]  sd_buff_din
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;

   state_t      state_q, state_d;
   logic        g_q, g_d;
   logic        last_q, last_d;
   logic [31:0] lba_q, lba_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  rd_q, rd_d;
   logic [1:0]  wr_q, wr_d;
   logic [1:0]  busy_q, busy_d;
   logic [1:0]  done_q, done_d;
   logic [1:0]  err_q, err_d;
   logic        ack_q;

   logic        req0, req1, win, win_rd, ack_rise, ack_fall, timeout_hit, xfer;
   logic [1:0]  win_mask, g_mask;

   always_comb begin
      req0        = (c0_rd | c0_wr) & ~busy_q[0];
      req1        = (c1_rd | c1_wr) & ~busy_q[1];
      // Contention goes to the client that did not win last; a lone requester always wins.
      win         = (req0 & req1) ? ~last_q : req1;
      win_mask    = win ? 2'b10 : 2'b01;
      win_rd      = win ? c1_rd : c0_rd;
      g_mask      = g_q ? 2'b10 : 2'b01;
      ack_rise    = sd_ack & ~ack_q;
      ack_fall    = ~sd_ack & ack_q;
      timeout_hit = (TIMEOUT != 32'd0) && (cnt_q == TIMEOUT - 32'd1);
      xfer        = (state_q == S_XFER);
   end

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      last_d  = last_q;
      lba_d   = lba_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      busy_d  = busy_q;
      done_d  = '0;
      err_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (req0 | req1) begin
               g_d     = win;
               last_d  = win;
               lba_d   = win ? c1_lba : c0_lba;
               rd_d    = win_rd ? win_mask : 2'b00;
               wr_d    = win_rd ? 2'b00 : win_mask;
               busy_d  = win_mask;
               cnt_d   = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
            if (ack_rise) begin
               rd_d    = '0;
               wr_d    = '0;
               state_d = S_XFER;
            end else if (timeout_hit) begin
               rd_d    = '0;
               wr_d    = '0;
               done_d  = g_mask;
               err_d   = g_mask;
               busy_d  = busy_q & ~g_mask;
               state_d = S_IDLE;
            end
         end
         S_XFER: begin
            if (ack_fall) begin
               done_d  = g_mask;
               busy_d  = busy_q & ~g_mask;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         g_q     <= 1'b0;
         last_q  <= 1'b1;
         lba_q   <= '0;
         cnt_q   <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         busy_q  <= '0;
         done_q  <= '0;
         err_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         last_q  <= last_d;
         lba_q   <= lba_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ack_q   <= sd_ack;
      end
   end

   assign sd_lba      = lba_q;
   assign sd_rd       = rd_q;
   assign sd_wr       = wr_q;
   assign c0_busy     = busy_q[0];
   assign c1_busy     = busy_q[1];
   assign c0_done     = done_q[0];
   assign c1_done     = done_q[1];
   assign c0_err      = err_q[0];
   assign c1_err      = err_q[1];
   assign c0_buff_wr  = xfer & ~g_q & sd_buff_wr;
   assign c1_buff_wr  = xfer & g_q & sd_buff_wr;
   assign sd_buff_din = xfer ? (g_q ? c1_buff_din : c0_buff_din) : '0;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Randomized bench for sd_req_arbiter with a transaction-level model of
// grant order, operation decode, buffer steering and timeout length.
module tb_sd_req_arbiter;

   localparam int TMO = 100;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [31:0] c0_lba, c1_lba;
   logic        c0_rd, c0_wr, c1_rd, c1_wr;
   logic        c0_busy, c0_done, c0_err, c0_buff_wr;
   logic        c1_busy, c1_done, c1_err, c1_buff_wr;
   logic [7:0]  c0_buff_din, c1_buff_din;
   logic [31:0] sd_lba;
   logic [1:0]  sd_rd, sd_wr;
   logic        sd_ack, sd_buff_wr;
   logic [7:0]  sd_buff_din;

   sd_req_arbiter #(.TIMEOUT(TMO)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .c0_lba(c0_lba), .c0_rd(c0_rd), .c0_wr(c0_wr), .c0_busy(c0_busy),
      .c0_done(c0_done), .c0_err(c0_err), .c0_buff_wr(c0_buff_wr), .c0_buff_din(c0_buff_din),
      .c1_lba(c1_lba), .c1_rd(c1_rd), .c1_wr(c1_wr), .c1_busy(c1_busy),
      .c1_done(c1_done), .c1_err(c1_err), .c1_buff_wr(c1_buff_wr), .c1_buff_din(c1_buff_din),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
   );

   always #5 clk_sys = ~clk_sys;

   int total = 0;
   int bad   = 0;
   int viol  = 0;

   // Client-side request state, the model's view of fairness, and grant history.
   logic        q_rd [2];
   logic        q_wr [2];
   logic [31:0] q_lba [2];
   int          last_g;
   int          order[$];
   int          fix_din = -1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic apply();
      c0_rd = q_rd[0]; c0_wr = q_wr[0]; c0_lba = q_lba[0];
      c1_rd = q_rd[1]; c1_wr = q_wr[1]; c1_lba = q_lba[1];
   endtask

   task automatic request(input int c, input logic rd, input logic wr, input logic [31:0] lba);
      q_rd[c] = rd; q_wr[c] = wr; q_lba[c] = lba;
      apply();
   endtask

   task automatic drop(input int c);
      q_rd[c] = 1'b0; q_wr[c] = 1'b0;
      apply();
   endtask

   function automatic logic [1:0] mask(input int c);
      return (c == 1) ? 2'b10 : 2'b01;
   endfunction

   function automatic int pick();
      bit r0, r1;
      r0 = q_rd[0] | q_wr[0];
      r1 = q_rd[1] | q_wr[1];
      if (r0 && r1) return 1 - last_g;
      return r0 ? 0 : 1;
   endfunction

   task automatic do_reset();
      reset_n = 1'b0;
      sd_ack = 1'b0; sd_buff_wr = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      last_g = 1;
   endtask

   // Serves one transaction: checks grant against the model, then plays the I/O controller.
   task automatic serve(input int ack_delay, input int nstrobes, input bit tmo, input bit stale);
      int          w, n, p_own, p_oth, dbad;
      bit          st;
      logic [7:0]  d0, d1, exp_d;
      logic        own, oth;
      w  = pick();
      st = stale && ((sd_rd | sd_wr) == 2'b00);
      if (st) sd_ack = 1'b1;
      if ((sd_rd | sd_wr) == 2'b00) tick();
      check("grant_rd",   sd_rd,  q_rd[w] ? mask(w) : 2'b00);
      check("grant_wr",   sd_wr,  q_rd[w] ? 2'b00 : mask(w));
      check("grant_lba",  sd_lba, q_lba[w]);
      check("grant_busy", {c1_busy, c0_busy}, mask(w));
      last_g = w;
      order.push_back(w);
      if (tmo) begin
         n = 0;
         while ((sd_rd | sd_wr) != 2'b00 && n < TMO + 10) begin
            tick();
            n++;
         end
         check("tmo_len",  n, TMO);
         check("tmo_done", {c1_done, c0_done}, mask(w));
         check("tmo_err",  {c1_err, c0_err}, mask(w));
         check("tmo_busy", {c1_busy, c0_busy}, 2'b00);
         drop(w);
         sd_ack = 1'b0;
         tick();
         check("tmo_clr", {c1_done, c0_done, c1_err, c0_err}, 4'b0000);
         return;
      end
      repeat (ack_delay) tick();
      check("issue_hold", sd_rd | sd_wr, mask(w));
      if (st) begin
         sd_ack = 1'b0;
         tick();
         check("stale_hold", sd_rd | sd_wr, mask(w));
      end
      c0_buff_din = 8'hFF; c1_buff_din = 8'hFF; sd_buff_wr = 1'b1;
      #1;
      check("issue_gate", {c1_buff_wr, c0_buff_wr, sd_buff_din}, 10'h000);
      sd_buff_wr = 1'b0;
      sd_ack = 1'b1;
      tick();
      check("ack_clr", {sd_rd, sd_wr}, 4'b0000);
      p_own = 0; p_oth = 0; dbad = 0;
      for (int i = 0; i < nstrobes; i++) begin
         d0 = 8'($urandom);
         d1 = ~d0;
         if (fix_din >= 0) begin
            if (w == 0) d0 = 8'(fix_din); else d1 = 8'(fix_din);
         end
         exp_d = (w == 1) ? d1 : d0;
         c0_buff_din = d0; c1_buff_din = d1;
         sd_buff_wr = 1'b1;
         #1;
         own = (w == 1) ? c1_buff_wr : c0_buff_wr;
         oth = (w == 1) ? c0_buff_wr : c1_buff_wr;
         if (own) p_own++;
         if (oth) p_oth++;
         if (sd_buff_din !== exp_d) dbad++;
         tick();
         sd_buff_wr = 1'b0;
         #1;
         if (c0_buff_wr | c1_buff_wr) p_oth++;
         tick();
      end
      check("strb_own", p_own, nstrobes);
      check("strb_oth", p_oth, 0);
      check("din_bad",  dbad, 0);
      sd_ack = 1'b0;
      tick();
      check("done_set",  {c1_done, c0_done}, mask(w));
      check("done_busy", {c1_busy, c0_busy}, 2'b00);
      check("done_err",  {c1_err, c0_err}, 2'b00);
      drop(w);
      tick();
      check("done_clr", {c1_done, c0_done}, 2'b00);
   endtask

   always @(negedge clk_sys) begin
      if ($countones(sd_rd | sd_wr) > 1) viol++;
      if (c0_busy && c1_busy) viol++;
      if ((c0_done && c0_busy) || (c1_done && c1_busy)) viol++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      q_rd[0] = 0; q_wr[0] = 0; q_lba[0] = '0;
      q_rd[1] = 0; q_wr[1] = 0; q_lba[1] = '0;
      apply();
      c0_buff_din = '0; c1_buff_din = '0;
      do_reset();
      check("rst_out", {sd_lba, sd_rd, sd_wr}, 36'h0);
      check("rst_cli", {c1_busy, c0_busy, c1_done, c0_done, c1_err, c0_err}, 6'h0);

      // Single read of 512 bytes
      request(0, 1'b1, 1'b0, 32'h0000_1234);
      serve(3, 512, 1'b0, 1'b0);

      // Simultaneous requests after reset: client 0 first, then client 1 write with 0xA5 data
      do_reset();
      q_rd[0] = 1; q_wr[0] = 0; q_lba[0] = 32'd5;
      q_rd[1] = 0; q_wr[1] = 1; q_lba[1] = 32'd9;
      apply();
      serve(1, 2, 1'b0, 1'b0);
      fix_din = 8'hA5;
      serve(1, 4, 1'b0, 1'b0);
      fix_din = -1;

      // Fairness under continuous contention
      base = order.size();
      request(0, 1'b1, 1'b0, 32'h100);
      request(1, 1'b0, 1'b1, 32'h200);
      for (int k = 0; k < 4; k++) begin
         serve(0, 1, 1'b0, 1'b0);
         request(order[order.size() - 1], 1'b1, 1'b0, 32'h300 + 32'(k));
      end
      for (int k = 0; k < 4; k++) check("fair_order", order[base + k], k % 2);
      drop(0); drop(1);
      tick(); tick();

      // Timeout on client 1
      request(1, 1'b1, 1'b0, 32'hDEAD_0001);
      serve(0, 0, 1'b1, 1'b0);

      // Stale ack already high at grant
      request(0, 1'b0, 1'b1, 32'h77);
      serve(3, 2, 1'b0, 1'b1);

      // Reset in the middle of a transfer
      request(0, 1'b1, 1'b0, 32'hABCD);
      tick();
      sd_ack = 1'b1;
      tick();
      reset_n = 1'b0;
      drop(0);
      sd_ack = 1'b0;
      tick();
      reset_n = 1'b1;
      last_g = 1;
      check("mrst_out", {sd_lba, sd_rd, sd_wr}, 36'h0);
      check("mrst_cli", {c1_busy, c0_busy, c1_done, c0_done, c1_err, c0_err}, 6'h0);
      tick();
      check("mrst_nodone", {c1_done, c0_done, sd_rd, sd_wr}, 6'h0);
      request(1, 1'b1, 1'b0, 32'h55);
      serve(2, 1, 1'b0, 1'b0);
      request(0, 1'b1, 1'b1, 32'h66);
      serve(1, 1, 1'b0, 1'b0);

      // Randomized traffic
      for (int it = 0; it < 30; it++) begin
         for (int c = 0; c < 2; c++) begin
            if (!(q_rd[c] | q_wr[c]) && $urandom_range(0, 1) == 1) begin
               q_rd[c] = 1'($urandom);
               q_wr[c] = ~q_rd[c] | 1'($urandom);
               q_lba[c] = $urandom;
            end
         end
         if (!(q_rd[0] | q_wr[0] | q_rd[1] | q_wr[1])) begin
            q_rd[it % 2] = 1'b1;
            q_lba[it % 2] = $urandom;
         end
         apply();
         serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
               $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      end

      check("invariants", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
